// File: rtl/vga_capture.sv
// vga_capture: recovers row/col coordinates from a sampled 640x480@60 VGA
// stream (hs/vs/RGB) and emits one pixel-RAM write per active pixel once the
// sync timing of a whole frame has been verified.
//
// Write interface: push-only, no back-pressure. When we=1 for one clk,
// wr_row/wr_col/wr_data carry a valid pixel that the RAM must accept that
// cycle. When we=0, wr_* hold their last value and carry no meaning.
module vga_capture #(
  parameter int H_TOTAL  = 800,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] rgb_in,
  output logic        we,
  output logic [9:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        err
);

  // Timeout counter is sized to hold 2*H_TOTAL without wrapping.
  localparam int TW = $clog2(2 * H_TOTAL + 1);

  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_BP_C   = 10'(H_BP);
  localparam logic [9:0]    V_BP_C   = 10'(V_BP);
  localparam logic [9:0]    H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0]    ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]    COL_LAST = 10'(H_ACTIVE - 1);
  // Timeout fires on the sample 2*H_TOTAL-1 after the last hs rise, so err
  // is registered exactly 2*H_TOTAL clocks after the edge that captured it.
  localparam logic [TW-1:0] T_LIMIT  = TW'(2 * H_TOTAL - 1);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state;

  // S1 input stage plus one-cycle delayed copies for edge detection.
  logic        hs_s1;
  logic        vs_s1;
  logic        hs_d;
  logic        vs_d;
  logic [11:0] rgb_s1;

  // *_cnt hold the count of the previous S1 sample; *_cur is the count that
  // belongs to the sample currently sitting in S1.
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [TW-1:0] t_cnt;
  logic [9:0]    h_cur;
  logic [9:0]    v_cur;
  logic [TW-1:0] t_cur;

  logic       hs_rise;
  logic       vs_rise;
  logic [9:0] col;
  logic [9:0] row;
  logic       pix_active;
  logic       line_bad;
  logic       frame_bad;
  logic       timeout;
  logic       fail;
  logic       wr_go;

  // Register the raw stream once. Syncs reset to their idle-high level so a
  // reset released mid-stream never shows up as a false hs/vs rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      hs_d   <= 1'b1;
      vs_d   <= 1'b1;
      rgb_s1 <= '0;
    end else begin
      hs_s1  <= hs_in;
      vs_s1  <= vs_in;
      hs_d   <= hs_s1;
      vs_d   <= vs_s1;
      rgb_s1 <= rgb_in;
    end
  end

  // Edge detection, per-sample counts, active-window test and timing checks.
  always_comb begin
    hs_rise = hs_s1 & ~hs_d;
    vs_rise = vs_s1 & ~vs_d;

    h_cur = h_cnt;
    if (hs_rise) begin
      h_cur = '0;
    end else if (h_cnt != 10'h3ff) begin
      h_cur = h_cnt + 10'd1;
    end

    // A vs rise wins over a coincident hs rise: the count clears, no increment.
    v_cur = v_cnt;
    if (vs_rise) begin
      v_cur = '0;
    end else if (hs_rise && (v_cnt != 10'h3ff)) begin
      v_cur = v_cnt + 10'd1;
    end

    t_cur = t_cnt;
    if (hs_rise) begin
      t_cur = '0;
    end else if (t_cnt != {TW{1'b1}}) begin
      t_cur = t_cnt + 1'b1;
    end

    // Unsigned 10-bit subtraction: samples before the porch wrap to large
    // values and fall outside the window with a single compare.
    col        = h_cur - H_BP_C;
    row        = v_cur - V_BP_C;
    pix_active = (col < H_ACT_C) && (row < V_ACT_C);

    // h_cnt/v_cnt still hold the last count before the rise here.
    line_bad  = hs_rise && (h_cnt != H_LAST);
    frame_bad = vs_rise && (v_cnt != V_LAST);
    timeout   = (t_cur >= T_LIMIT);
    fail      = (state != SEEK) && (line_bad || frame_bad || timeout);

    wr_go = (state == LOCKED) && pix_active && !fail;
  end

  // Counters advance once per S1 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      t_cnt <= '0;
    end else begin
      h_cnt <= h_cur;
      v_cnt <= v_cur;
      t_cnt <= t_cur;
    end
  end

  // Lock FSM: SEEK waits for a frame start, CHECK qualifies one full frame,
  // LOCKED keeps checking and drops back to SEEK on the first mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEEK;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        SEEK: begin
          if (vs_rise) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (fail) begin
            err   <= 1'b1;
            state <= SEEK;
          end else if (vs_rise) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (fail) begin
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= SEEK;
          end
        end
        default: begin
          state  <= SEEK;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: one strobe per active pixel while locked; address/data hold
  // between strobes. frame_done follows the write of the last pixel by 1 clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= wr_go;
      frame_done <= we && (wr_row == ROW_LAST) && (wr_col == COL_LAST);
      if (wr_go) begin
        wr_row  <= row;
        wr_col  <= col;
        wr_data <= rgb_s1;
      end
    end
  end

endmodule
